// File: rtl/seq_pkg.sv
// Shared constants for the serial-bit input path and the sequence detector.
package seq_pkg;
  localparam int   DEFAULT_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms at 100 MHz
  localparam int   DEFAULT_FIFO_DEPTH      = 4;
  localparam logic BIT_ZERO                = 1'b0;
  localparam logic BIT_ONE                 = 1'b1;
endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer, mismatch-counting debouncer and press strobe for
// one raw button/VIO level.
module debounce_sync
  import seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_press
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_mismatch;
  logic          w_expire;

  assign w_mismatch = r_sync2 ^ r_stable;
  assign w_expire   = w_mismatch && (r_cnt == CNT_MAX);

  // Bring the asynchronous level into the clock domain.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a level change only after it has persisted; any agreement restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (!w_mismatch) begin
      r_cnt <= '0;
    end else if (w_expire) begin
      r_stable <= ~r_stable;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Strobe coincides with the edge at which stable goes 0->1; releases are silent.
  assign o_press = w_expire & ~r_stable;

endmodule

// File: rtl/seq_bit_source.sv
// Turns debounced "enter 0" / "enter 1" presses into a queued serial bit
// stream with a valid/ready interface toward the sequence detector.
module seq_bit_source
  import seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = DEFAULT_FIFO_DEPTH
) (
  input  logic                        clk_100M,
  input  logic                        clear_n,
  input  logic                        input_0,
  input  logic                        input_1,
  output logic                        bit_valid,
  output logic                        bit_data,
  input  logic                        bit_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        conflict
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic          w_press_0;
  logic          w_press_1;
  logic          w_event;
  logic          w_both;
  logic          w_event_bit;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_conflict;
  logic          r_mem [FIFO_DEPTH];

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_0 (
    .i_clk   (clk_100M),
    .i_rst_n (clear_n),
    .i_raw   (input_0),
    .o_press (w_press_0)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_1 (
    .i_clk   (clk_100M),
    .i_rst_n (clear_n),
    .i_raw   (input_1),
    .o_press (w_press_1)
  );

  // Simultaneous presses are ambiguous, so neither is queued.
  assign w_event     = w_press_0 ^ w_press_1;
  assign w_both      = w_press_0 & w_press_1;
  assign w_event_bit = w_press_1 ? BIT_ONE : BIT_ZERO;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = !w_empty && bit_ready;
  assign w_push  = w_event && (!w_full || w_pop);

  // Pointer, occupancy and sticky-flag bookkeeping.
  always_ff @(posedge clk_100M or negedge clear_n) begin
    if (!clear_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_event && w_full && !w_pop) r_overflow <= 1'b1;
      if (w_both)                      r_conflict <= 1'b1;
    end
  end

  // Bit storage; contents are only observed through the occupancy-gated head.
  always_ff @(posedge clk_100M) begin
    if (w_push) r_mem[r_wptr] <= w_event_bit;
  end

  assign bit_valid  = !w_empty;
  assign bit_data   = !w_empty && r_mem[r_rptr];
  assign fifo_count = r_count;
  assign overflow   = r_overflow;
  assign conflict   = r_conflict;

endmodule

// File: tb/tb_seq_bit_source.sv
// Self-checking bench for seq_bit_source with short debounce and a 4-deep FIFO.
module tb_seq_bit_source;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk_100M;
  logic       clear_n;
  logic       input_0;
  logic       input_1;
  logic       bit_valid;
  logic       bit_data;
  logic       bit_ready;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       conflict;

  int n_tests;
  int n_fail;
  bit sb_q[$];

  typedef struct {
    logic b0;
    logic b1;
    logic coincide;  // pulse bit_ready exactly on the push edge
    int   exp_count;
    logic exp_ovf;
    logic exp_conf;
    logic drain;     // drain and verify the whole queue afterwards
  } vec_t;

  vec_t tbl[13];

  seq_bit_source #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk_100M   (clk_100M),
    .clear_n    (clear_n),
    .input_0    (input_0),
    .input_1    (input_1),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .bit_ready  (bit_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .conflict   (conflict)
  );

  initial clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  // Hold the given levels long enough for a press, then release and let it settle.
  task automatic press(input logic b0, input logic b1, input logic coincide);
    bit head;
    if ((b0 ^ b1) && (sb_q.size() < DEPTH || coincide)) sb_q.push_back(b1);
    input_0 = b0;
    input_1 = b1;
    if (coincide) begin
      repeat (5) tick();
      bit_ready = 1'b1;
      @(negedge clk_100M);
      head = sb_q.pop_front();
      check("coincide_valid", bit_valid, 1);
      check("coincide_head", bit_data, head);
      tick();
      bit_ready = 1'b0;
      repeat (4) tick();
    end else begin
      repeat (10) tick();
    end
    input_0 = 1'b0;
    input_1 = 1'b0;
    repeat (8) tick();
  endtask

  // Pop everything with bit_ready held, one bit per cycle, then confirm empty.
  task automatic drain();
    int  n;
    bit  exp_bit;
    n = sb_q.size();
    bit_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_100M);
      exp_bit = sb_q.pop_front();
      check("drain_valid", bit_valid, 1);
      check("drain_data", bit_data, exp_bit);
      tick();
    end
    @(negedge clk_100M);
    check("drain_empty_valid", bit_valid, 0);
    check("drain_empty_count", fifo_count, 0);
    #1;
    bit_ready = 1'b0;
  endtask

  // Press a single input from idle and check the exact edge at which it appears.
  task automatic latency_press(input logic b);
    sb_q.push_back(b);
    input_0 = ~b;
    input_1 = b;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e == 5) check("lat_early_valid", bit_valid, 0);
      if (e == 6) begin
        check("lat_valid", bit_valid, 1);
        check("lat_data", bit_data, b);
        check("lat_count", fifo_count, 1);
      end
    end
    repeat (4) tick();
    input_0 = 1'b0;
    input_1 = 1'b0;
    repeat (10) tick();
    check("release_no_bit", fifo_count, 1);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    clear_n   = 1'b0;
    input_0   = 1'b0;
    input_1   = 1'b0;
    bit_ready = 1'b0;

    //            b0    b1    co    cnt ovf   conf  drain
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 3, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b1};

    // Reset state
    repeat (3) tick();
    check("rst_valid", bit_valid, 0);
    check("rst_data", bit_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_conf", conflict, 0);
    clear_n = 1'b1;
    repeat (2) tick();

    // Single press latency and silent release
    latency_press(1'b1);
    drain();

    // Short pulses never reach the debounce threshold
    for (int k = 0; k < 4; k++) begin
      input_0 = 1'b1;
      repeat (3) tick();
      input_0 = 1'b0;
      repeat (2) tick();
      check("glitch_valid", bit_valid, 0);
      check("glitch_count", fifo_count, 0);
    end
    repeat (8) tick();
    check("glitch_final_count", fifo_count, 0);

    // Ordering, full-FIFO coincident pop, overflow and conflict vectors
    for (int i = 0; i < 13; i++) begin
      press(tbl[i].b0, tbl[i].b1, tbl[i].coincide);
      check($sformatf("vec%0d_count", i), fifo_count, tbl[i].exp_count);
      check($sformatf("vec%0d_valid", i), bit_valid, (tbl[i].exp_count != 0) ? 1 : 0);
      check($sformatf("vec%0d_ovf", i), overflow, tbl[i].exp_ovf);
      check($sformatf("vec%0d_conf", i), conflict, tbl[i].exp_conf);
      if (tbl[i].drain) drain();
    end

    // Reset with three bits queued and a debounce in progress
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("pre_rst_count", fifo_count, 3);
    input_1 = 1'b1;
    repeat (4) tick();
    #2;
    clear_n = 1'b0;
    #1;
    check("async_rst_valid", bit_valid, 0);
    check("async_rst_count", fifo_count, 0);
    check("async_rst_ovf", overflow, 0);
    check("async_rst_conf", conflict, 0);
    sb_q.delete();
    input_1 = 1'b0;
    repeat (2) tick();
    clear_n = 1'b1;
    repeat (2) tick();
    latency_press(1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
